// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the sequential RV64 core: steps the shared datapath
// through FETCH/DECODE/EXEC/MEM/WB and drives per-phase enables and mux selects.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_src,
  output logic        ir_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CLS_R   = 2'd0,
    CLS_LD  = 2'd1,
    CLS_SD  = 2'd2,
    CLS_BEQ = 2'd3
  } cls_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  // Fault fires on the edge that would bring the counter to MEM_TIMEOUT.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state;
  cls_t        cls;
  logic [7:0]  wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cls      <= CLS_R;
      wait_cnt <= 8'd0;
      retired  <= 32'd0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            wait_cnt <= 8'd0;
          end
        end
        S_FETCH, S_MEM: begin
          if (mem_ready) begin
            wait_cnt <= 8'd0;
            if (state == S_FETCH) begin
              state <= S_DECODE;
            end else if (cls == CLS_SD) begin
              state   <= S_FETCH;
              retired <= retired + 32'd1;
            end else begin
              state <= S_WB;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == WAIT_LAST) begin
              state <= S_HALT;
              err   <= 1'b1;
            end
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_R:    begin cls <= CLS_R;   state <= S_EXEC; end
            OP_LD:   begin cls <= CLS_LD;  state <= S_EXEC; end
            OP_SD:   begin cls <= CLS_SD;  state <= S_EXEC; end
            OP_BEQ:  begin cls <= CLS_BEQ; state <= S_EXEC; end
            OP_SYS:  state <= S_HALT;
            default: begin state <= S_HALT; err <= 1'b1; end
          endcase
        end
        S_EXEC: begin
          case (cls)
            CLS_R: state <= S_WB;
            CLS_LD, CLS_SD: begin
              state    <= S_MEM;
              wait_cnt <= 8'd0;
            end
            default: begin
              state    <= S_FETCH;
              wait_cnt <= 8'd0;
              retired  <= retired + 32'd1;
            end
          endcase
        end
        S_WB: begin
          state    <= S_FETCH;
          wait_cnt <= 8'd0;
          retired  <= retired + 32'd1;
        end
        S_HALT: ;
        default: begin
          state <= S_HALT;
          err   <= 1'b1;
        end
      endcase
    end
  end

  // Strobes decode straight from the state register so an asynchronous reset
  // clears them immediately; only pc_write/ir_write look at live inputs.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC: begin
        case (cls)
          CLS_R: alu_op = 2'b10;
          CLS_LD, CLS_SD: alu_src = 1'b1;
          default: begin
            alu_op   = 2'b01;
            pc_src   = 1'b1;
            pc_write = zero;
          end
        endcase
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        alu_src   = 1'b1;
        mem_read  = (cls == CLS_LD);
        mem_write = (cls == CLS_SD);
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls == CLS_LD);
      end
      default: ;
    endcase
  end

  assign busy   = (state != S_IDLE) && (state != S_HALT);
  assign halted = (state == S_HALT);

endmodule
